// File: rtl/vga_pkg.sv
// Shared raster definitions for the VGA pixel pipeline: tile command codes,
// 640x480@75 mode timing and the tile scheduler state encoding.
package vga_pkg;

   localparam logic [1:0] CMD_IDLE    = 2'd0;
   localparam logic [1:0] CMD_RESTART = 2'd1;
   localparam logic [1:0] CMD_STEPY   = 2'd2;
   localparam logic [1:0] CMD_STEPX   = 2'd3;

   localparam int H_VISIBLE    = 640;
   localparam int H_SYNC_START = 656;
   localparam int H_SYNC_END   = 720;
   localparam int H_TOTAL      = 840;
   localparam int V_VISIBLE    = 480;
   localparam int V_SYNC_START = 481;
   localparam int V_SYNC_END   = 484;
   localparam int V_TOTAL      = 500;

   localparam int COEF_PER_TILE = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_SWAP    = 2'd2
   } sched_state_e;

endpackage

// File: rtl/tile_cmd_gen.sv
// Turns the raster position into the registered tile command and flags the
// frame boundary (first pixel of vertical blank) combinationally.
module tile_cmd_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   output logic [1:0] command,
   output logic       frame_boundary
);

   localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT = 10'(V_ACTIVE);

   logic [1:0] command_d;
   logic [1:0] command_q;

   always_comb begin
      command_d = CMD_IDLE;
      if (y == V_ACT) begin
         command_d = CMD_RESTART;
      end else if (x == H_ACT) begin
         command_d = CMD_STEPY;
      end else if ((x < H_ACT) && (y < V_ACT)) begin
         command_d = CMD_STEPX;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         command_q <= CMD_IDLE;
      end else begin
         command_q <= command_d;
      end
   end

   assign command        = command_q;
   assign frame_boundary = (y == V_ACT) && (x == 10'd0);

endmodule

// File: rtl/tile_scheduler.sv
// Tile command sequencing plus double-buffered tile coefficients: host writes
// land in shadow registers and a commit is copied to the active set at vblank.
module tile_scheduler
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int NTILES   = 3,
   parameter int COEF_W   = 54
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic [9:0]                               x,
   input  logic [9:0]                               y,
   output logic [1:0]                               command,
   input  logic                                     cfg_valid,
   output logic                                     cfg_ready,
   input  logic [1:0]                               cfg_tile,
   input  logic [1:0]                               cfg_sel,
   input  logic [COEF_W-1:0]                        cfg_data,
   input  logic                                     cfg_commit,
   output logic                                     cfg_err,
   output logic                                     swap_done,
   output logic [15:0]                              frame_count,
   output logic [NTILES*COEF_PER_TILE*COEF_W-1:0]   coef
);

   localparam int NCOEF = NTILES * COEF_PER_TILE;

   sched_state_e state_q;
   sched_state_e state_d;
   logic         frame_boundary;
   logic         wr_fire;
   logic         wr_illegal;
   logic         take_swap;
   logic         cfg_err_q;
   logic         swap_done_q;
   logic [15:0]  frame_count_q;

   tile_cmd_gen #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE)
   ) u_cmd_gen (
      .clock          (clock),
      .reset          (reset),
      .x              (x),
      .y              (y),
      .command        (command),
      .frame_boundary (frame_boundary)
   );

   assign cfg_ready  = (state_q == ST_IDLE);
   assign wr_fire    = cfg_valid && cfg_ready;
   assign wr_illegal = (int'(cfg_tile) >= NTILES) || (cfg_sel == 2'd3);
   // Shadow cannot change while PENDING, so the snapshot taken here is exactly what was committed.
   assign take_swap  = (state_q == ST_PENDING) && frame_boundary;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (cfg_commit) state_d = ST_PENDING;
         ST_PENDING: if (frame_boundary) state_d = ST_SWAP;
         ST_SWAP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cfg_err_q     <= 1'b0;
         swap_done_q   <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cfg_err_q   <= wr_fire && wr_illegal;
         swap_done_q <= (state_q == ST_SWAP);
         if (frame_boundary) begin
            frame_count_q <= frame_count_q + 16'd1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCOEF; gi++) begin : g_coef
         localparam logic [1:0] TILE = 2'(gi / COEF_PER_TILE);
         localparam logic [1:0] SEL  = 2'(gi % COEF_PER_TILE);

         logic [COEF_W-1:0] shadow_q;
         logic [COEF_W-1:0] active_q;
         logic              wr_hit;

         assign wr_hit = wr_fire && !wr_illegal && (cfg_tile == TILE) && (cfg_sel == SEL);

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               shadow_q <= '0;
               active_q <= '0;
            end else begin
               if (wr_hit) begin
                  shadow_q <= cfg_data;
               end
               if (take_swap) begin
                  active_q <= shadow_q;
               end
            end
         end

         assign coef[gi*COEF_W +: COEF_W] = active_q;
      end
   endgenerate

   assign cfg_err     = cfg_err_q;
   assign swap_done   = swap_done_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomized scoreboard bench for tile_scheduler against a frame-level
// reference model of the commit/swap protocol.
module tb_tile_scheduler;

   localparam int NT  = 3;
   localparam int CW  = 54;
   localparam int NC  = NT * 3;
   localparam int TOT = NC * CW;

   typedef struct {
      int             due;
      logic [1:0]     cmd;
      logic           rdy;
      logic           err;
      logic           sd;
      logic [15:0]    fc;
      logic [TOT-1:0] coef;
   } exp_t;

   logic           clock;
   logic           reset;
   logic [9:0]     x;
   logic [9:0]     y;
   logic [1:0]     command;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [1:0]     cfg_tile;
   logic [1:0]     cfg_sel;
   logic [CW-1:0]  cfg_data;
   logic           cfg_commit;
   logic           cfg_err;
   logic           swap_done;
   logic [15:0]    frame_count;
   logic [TOT-1:0] coef;

   tile_scheduler #(
      .H_ACTIVE (640),
      .V_ACTIVE (480),
      .NTILES   (NT),
      .COEF_W   (CW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .x           (x),
      .y           (y),
      .command     (command),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_tile    (cfg_tile),
      .cfg_sel     (cfg_sel),
      .cfg_data    (cfg_data),
      .cfg_commit  (cfg_commit),
      .cfg_err     (cfg_err),
      .swap_done   (swap_done),
      .frame_count (frame_count),
      .coef        (coef)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   exp_t exp_q[$];
   int   vectors    = 0;
   int   miscompares = 0;

   // Reference model: a commit waits for the next vblank start, then the
   // whole shadow set becomes active for the following frame.
   logic [CW-1:0] m_shadow [NC];
   logic [CW-1:0] m_active [NC];
   logic          m_waiting;
   logic          m_swapping;
   logic [15:0]   m_frames;

   // Pending host requests consumed by the driver.
   logic          wr_pend  = 1'b0;
   logic [1:0]    wr_tile  = 2'd0;
   logic [1:0]    wr_sel   = 2'd0;
   logic [CW-1:0] wr_data  = '0;
   logic          com_req  = 1'b0;

   function automatic logic [1:0] exp_cmd(input int xi, input int yi);
      if (yi == 480) return 2'd1;
      if (xi == 640) return 2'd2;
      if (xi < 640 && yi < 480) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [TOT-1:0] model_coef();
      logic [TOT-1:0] v;
      v = '0;
      for (int i = 0; i < NC; i++) v[i*CW +: CW] = m_active[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_waiting  = 1'b0;
      m_swapping = 1'b0;
      m_frames   = 16'd0;
   endtask

   task automatic push_reset_exp(input int due);
      exp_t e;
      e.due = due; e.cmd = 2'd0; e.rdy = 1'b1; e.err = 1'b0; e.sd = 1'b0;
      e.fc = 16'd0; e.coef = '0;
      exp_q.push_back(e);
   endtask

   task automatic compare(input string name, input logic [TOT-1:0] got,
                          input logic [TOT-1:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, want);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         e = exp_q.pop_front();
         vectors++;
         miscompares++;
         $display("FAIL stale_expectation cycle=%0d got=none expected_due=%0d", cyc, e.due);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         compare("command",     TOT'(command),     TOT'(e.cmd));
         compare("cfg_ready",   TOT'(cfg_ready),   TOT'(e.rdy));
         compare("cfg_err",     TOT'(cfg_err),     TOT'(e.err));
         compare("swap_done",   TOT'(swap_done),   TOT'(e.sd));
         compare("frame_count", TOT'(frame_count), TOT'(e.fc));
         compare("coef",        coef,              e.coef);
      end
   end

   // One clock of stimulus: drive inputs, advance the model, queue what the
   // DUT must show in the next cycle.
   task automatic tick(input logic r, input int xi, input int yi);
      int   n;
      exp_t e;
      logic rdy;
      logic fb;
      logic illegal;
      logic accepted;
      @(posedge clock);
      #1;
      n          = cyc;
      reset      = r;
      x          = 10'(xi);
      y          = 10'(yi);
      cfg_valid  = wr_pend;
      cfg_tile   = wr_tile;
      cfg_sel    = wr_sel;
      cfg_data   = wr_data;
      cfg_commit = com_req;
      if (r) begin
         while (exp_q.size() > 0 && exp_q[$].due >= n) void'(exp_q.pop_back());
         model_reset();
         push_reset_exp(n);
         push_reset_exp(n + 1);
         wr_pend = 1'b0;
         com_req = 1'b0;
      end else begin
         rdy      = !m_waiting && !m_swapping;
         fb       = (xi == 0) && (yi == 480);
         illegal  = (int'(wr_tile) >= NT) || (wr_sel == 2'd3);
         accepted = wr_pend && rdy;
         e.due    = n + 1;
         e.cmd    = exp_cmd(xi, yi);
         e.err    = accepted && illegal;
         e.sd     = m_swapping;
         if (fb) m_frames = m_frames + 16'd1;
         if (accepted && !illegal) m_shadow[int'(wr_tile)*3 + int'(wr_sel)] = wr_data;
         if (m_waiting && fb) begin
            for (int i = 0; i < NC; i++) m_active[i] = m_shadow[i];
            m_waiting  = 1'b0;
            m_swapping = 1'b1;
         end else begin
            m_swapping = 1'b0;
            if (rdy && com_req) m_waiting = 1'b1;
         end
         e.rdy  = !m_waiting && !m_swapping;
         e.fc   = m_frames;
         e.coef = model_coef();
         exp_q.push_back(e);
         if (accepted) wr_pend = 1'b0;
         com_req = 1'b0;
      end
   endtask

   task automatic line(input int yy);
      int xs[10];
      xs = '{0, 1, 2, 3, 638, 639, 640, 641, 642, 839};
      for (int i = 0; i < 10; i++) tick(1'b0, xs[i], yy);
   endtask

   task automatic wr(input logic [1:0] t, input logic [1:0] s, input logic [CW-1:0] d);
      wr_pend = 1'b1;
      wr_tile = t;
      wr_sel  = s;
      wr_data = d;
   endtask

   function automatic logic [CW-1:0] rnd_coef();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[CW-1:0];
   endfunction

   initial begin
      int sweep_y[7];
      sweep_y = '{0, 1, 239, 479, 480, 481, 499};
      reset = 1'b1; x = '0; y = '0;
      cfg_valid = 1'b0; cfg_tile = '0; cfg_sel = '0; cfg_data = '0; cfg_commit = 1'b0;
      model_reset();

      tick(1'b1, 0, 0);
      tick(1'b1, 0, 0);
      for (int i = 0; i < 20; i++) tick(1'b0, 300 + i, 200);
      tick(1'b1, 320, 200);
      tick(1'b1, 321, 200);

      // Command decode over whole representative lines.
      for (int k = 0; k < 7; k++)
         for (int xi = 0; xi < 840; xi++) tick(1'b0, xi, sweep_y[k]);

      // Write then commit mid-frame; swap lands at the next vblank start.
      wr(2'd1, 2'd2, 54'h10bacff0ab114c);
      line(99);
      com_req = 1'b1;
      line(100); line(479); line(480); line(481); line(0);

      // Write together with commit, then a write that must stall until after the swap.
      wr(2'd0, 2'd0, 54'h3ff7dfffb00097);
      com_req = 1'b1;
      line(200);
      wr(2'd2, 2'd1, rnd_coef());
      line(300); line(480); line(481); line(0);
      com_req = 1'b1;
      line(10); line(480); line(481);

      // Illegal targets, then a commit that re-applies the unchanged shadow.
      wr(2'd3, 2'd0, rnd_coef());
      line(10);
      wr(2'd0, 2'd3, rnd_coef());
      line(10);
      com_req = 1'b1;
      line(20); line(480); line(481);

      // Commit on the boundary cycle itself waits a full frame.
      line(479);
      com_req = 1'b1;
      line(480); line(481); line(0); line(480); line(481);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         int xi, yi;
         if ($urandom_range(7) == 0) begin
            xi = 0; yi = 480;
         end else begin
            xi = int'($urandom_range(839)); yi = int'($urandom_range(499));
         end
         if (!wr_pend && $urandom_range(3) == 0)
            wr(2'($urandom_range(3)), 2'($urandom_range(3)), rnd_coef());
         if ($urandom_range(15) == 0) com_req = 1'b1;
         tick(1'b0, xi, yi);
      end

      // Reset while a commit is pending discards it.
      wr(2'd2, 2'd2, rnd_coef());
      com_req = 1'b1;
      line(100);
      tick(1'b1, 5, 100);
      tick(1'b1, 6, 100);
      line(480); line(481);

      // frame_count wrap: one frame boundary per cycle.
      for (int i = 0; i < 65536; i++) tick(1'b0, 0, 480);
      tick(1'b0, 5, 5);
      tick(1'b0, 6, 5);

      @(posedge clock);
      @(negedge clock);
      #1;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain got=%0d expected=0 leftover entries", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
